// File: rtl/emesh_pkg.sv
// Shared types for the eMesh register responder.
// Datamode encodings, register indices and the reply entry.
package emesh_pkg;

  typedef enum logic [1:0] {
    DM_BYTE   = 2'b00,
    DM_HALF   = 2'b01,
    DM_WORD   = 2'b10,
    DM_DOUBLE = 2'b11
  } datamode_e;

  localparam logic [2:0] REG_WRCNT = 3'd6;
  localparam logic [2:0] REG_ID    = 3'd7;
  localparam int         N_SCR     = 6;

  typedef struct packed {
    logic [3:0]  ctrlmode;
    logic [31:0] dstaddr;
    logic [31:0] srcaddr;
    logic [31:0] data;
  } rsp_t;

  localparam int RSP_W = $bits(rsp_t);

  function automatic logic [3:0] lane_mask(
    input logic [1:0] dm,
    input logic [1:0] a
  );
    case (dm)
      DM_BYTE: return 4'b0001 << a;
      DM_HALF: return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(
    input logic [1:0]  dm,
    input logic [31:0] d
  );
    case (dm)
      DM_BYTE: return {4{d[7:0]}};
      DM_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/emesh_reg_responder_if.sv
// eMesh transaction bundle: one direction of traffic
// plus the wait signals flowing back against it.
interface emesh_reg_responder_if;
  logic        access;
  logic        write;
  logic [1:0]  datamode;
  logic [3:0]  ctrlmode;
  logic [31:0] dstaddr;
  logic [31:0] srcaddr;
  logic [31:0] data;
  logic        wr_wait;
  logic        rd_wait;

  modport master (
    output access, write, datamode, ctrlmode,
    output dstaddr, srcaddr, data,
    input  wr_wait, rd_wait
  );

  modport slave (
    input  access, write, datamode, ctrlmode,
    input  dstaddr, srcaddr, data,
    output wr_wait, rd_wait
  );
endinterface

// File: rtl/emesh_rsp_fifo.sv
// Depth 1/2 reply buffer; slot 0 is always the head so
// the outbound fields come straight from flops.
module emesh_rsp_fifo
  import emesh_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  rsp_t       push_data,
  input  logic       pop,
  output logic [1:0] count,
  output logic       head_valid,
  output rsp_t       head
);

  rsp_t             mem_q [DEPTH];
  rsp_t             mem_d [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic             placed;

  always_comb begin
    mem_d  = mem_q;
    vld_d  = vld_q;
    placed = 1'b0;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i+1];
        vld_d[i] = vld_q[i+1];
      end
      vld_d[DEPTH-1] = 1'b0;
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!placed && !vld_d[i]) begin
          mem_d[i] = push_data;
          vld_d[i] = 1'b1;
          placed   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++)
      count = count + {1'b0, vld_q[i]};
  end

  assign head_valid = vld_q[0];
  assign head       = mem_q[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/emesh_reg_responder.sv
// eMesh register target: 8-entry bank, read replies buffered.
// EMESH_RSP_SKID_EN selects a 2-deep reply buffer (default 1).
module emesh_reg_responder
  import emesh_pkg::*;
#(
  parameter logic [11:0] BASE_COORD = 12'h810,
  parameter logic [31:0] ID_VALUE   = 32'h0000_0E11
) (
  input logic                   eclk,
  input logic                   reset,
  emesh_reg_responder_if.slave  rx,
  emesh_reg_responder_if.master tx
);

`ifdef EMESH_RSP_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic [31:0] scratch_q [N_SCR];
  logic [31:0] scratch_d [N_SCR];
  logic [31:0] wrcnt_q;
  logic [31:0] wrcnt_d;

  logic [1:0]  fifo_cnt;
  logic        head_valid;
  rsp_t        head;
  rsp_t        rsp_c;
  logic        wait_c;
  logic        accept;
  logic        hit;
  logic        do_wr;
  logic        do_rd;
  logic        pop;
  logic [2:0]  idx;
  logic [3:0]  mask;
  logic [31:0] wd;
  logic [31:0] rd_val;
  logic        unused_ok;

  assign wait_c = reset | (fifo_cnt == 2'(DEPTH));
  assign accept = rx.access & ~wait_c;
  assign hit    = rx.dstaddr[31:20] == BASE_COORD;
  assign do_wr  = accept & hit & rx.write;
  assign do_rd  = accept & hit & ~rx.write;
  assign idx    = rx.dstaddr[4:2];
  assign mask   = lane_mask(rx.datamode, rx.dstaddr[1:0]);
  assign wd     = lane_data(rx.datamode, rx.data);

  assign rx.wr_wait = wait_c;
  assign rx.rd_wait = wait_c;

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < N_SCR; i++)
      if (idx == 3'(i)) rd_val = scratch_q[i];
    case (idx)
      REG_WRCNT: rd_val = wrcnt_q;
      REG_ID:    rd_val = ID_VALUE;
      default:   ;
    endcase
  end

  // Writes to 6/7 still bump the counter but touch no storage.
  always_comb begin
    scratch_d = scratch_q;
    wrcnt_d   = wrcnt_q;
    if (do_wr) begin
      wrcnt_d = wrcnt_q + 32'd1;
      for (int i = 0; i < N_SCR; i++)
        if (idx == 3'(i))
          for (int b = 0; b < 4; b++)
            if (mask[b])
              scratch_d[i][8*b +: 8] = wd[8*b +: 8];
    end
  end

  always_ff @(posedge eclk) begin
    if (reset) begin
      wrcnt_q <= '0;
      for (int i = 0; i < N_SCR; i++)
        scratch_q[i] <= '0;
    end else begin
      wrcnt_q   <= wrcnt_d;
      scratch_q <= scratch_d;
    end
  end

  assign rsp_c = '{
    ctrlmode: rx.ctrlmode,
    dstaddr:  rx.srcaddr,
    srcaddr:  rx.dstaddr,
    data:     rd_val
  };

  assign pop = head_valid & ~tx.wr_wait;

  emesh_rsp_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (eclk),
    .rst        (reset),
    .push       (do_rd),
    .push_data  (rsp_c),
    .pop        (pop),
    .count      (fifo_cnt),
    .head_valid (head_valid),
    .head       (head)
  );

  assign tx.access   = head_valid;
  assign tx.write    = head_valid;
  assign tx.datamode = {head_valid, 1'b0};
  assign tx.ctrlmode = head.ctrlmode;
  assign tx.dstaddr  = head.dstaddr;
  assign tx.srcaddr  = head.srcaddr;
  assign tx.data     = head.data;

  assign unused_ok = ^{rx.dstaddr[19:5], tx.rd_wait};

endmodule
